// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the master FSM state encoding,
// shared between the master command block and the slave block.
package axi_lite_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP_HOLD
    } axi_state_e;
endpackage

// File: rtl/axi_lite_timeout_cnt.sv
// axi_lite_timeout_cnt: saturating wait-cycle counter; expired_o fires in the
// cycle whose count would reach TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 disables it.
module axi_lite_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign expired_o = (TIMEOUT_CYCLES > 0) && en_i && !clr_i && (cnt_q == LAST);
endmodule

// File: rtl/axi_lite_master_cmd.sv
// axi_lite_master_cmd: runs one AXI4-Lite read or write per accepted command
// and returns data/status on a response port; all bus outputs are registered.
module axi_lite_master_cmd
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [2:0]              axi_awprot,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic [1:0]              axi_bresp,
    input  logic                    axi_bvalid,
    output logic                    axi_bready,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [2:0]              axi_arprot,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rvalid,
    output logic                    axi_rready
);
    localparam int SW = DATA_WIDTH / 8;
    axi_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  any_hs, active, tmr_clr, expired;

    assign cmd_ready   = state_q == ST_IDLE;
    assign axi_awaddr  = addr_q;
    assign axi_araddr  = addr_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_awprot  = 3'b000;
    assign axi_arprot  = 3'b000;
    assign axi_awvalid = awvalid_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    assign any_hs  = (awvalid_q & axi_awready) | (wvalid_q & axi_wready) | (bready_q & axi_bvalid)
                   | (arvalid_q & axi_arready) | (rready_q & axi_rvalid);
    assign active  = state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_DATA};
    assign tmr_clr = (cmd_ready & cmd_valid) | any_hs;

    axi_lite_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
        .clk_i    (axi_clk),
        .rst_ni   (axi_reset),
        .clr_i    (tmr_clr),
        .en_i     (active),
        .expired_o(expired)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                addr_d        = cmd_addr;
                wdata_d       = cmd_wdata;
                wstrb_d       = cmd_wstrb;
                rsp_timeout_d = 1'b0;
                awvalid_d     = cmd_write;
                wvalid_d      = cmd_write;
                arvalid_d     = !cmd_write;
                state_d       = cmd_write ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
                awvalid_d = awvalid_q & ~axi_awready;
                wvalid_d  = wvalid_q & ~axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (axi_bvalid) begin
                bready_d    = 1'b0;
                rsp_resp_d  = axi_bresp;
                rsp_rdata_d = '0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP_HOLD;
            end
            ST_RD_REQ: if (axi_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = ST_RD_DATA;
            end
            ST_RD_DATA: if (axi_rvalid) begin
                rready_d    = 1'b0;
                rsp_rdata_d = axi_rdata;
                rsp_resp_d  = axi_rresp;
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP_HOLD;
            end
            ST_RSP_HOLD: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Expiry only fires in a cycle with no handshake, so it cannot race a completion.
        if (expired) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_resp_d    = AXI_RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RSP_HOLD;
        end
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
endmodule
